// File: rtl/alu_serial.sv
// Digit-serial ALU: SLICE bits per RUN cycle, WIDTH/SLICE cycles per op.
// Valid/ready request port in, valid/ready result port out, one op in flight.
module alu_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] C_ADD  = 3'd0;
    localparam logic [2:0] C_SUB  = 3'd1;
    localparam logic [2:0] C_XOR  = 3'd2;
    localparam logic [2:0] C_SLT  = 3'd3;
    localparam logic [2:0] C_AND  = 3'd4;
    localparam logic [2:0] C_NAND = 3'd5;
    localparam logic [2:0] C_NOR  = 3'd6;
    localparam logic [2:0] C_OR   = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             carryout_q, carryout_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;

    logic             accept, last, is_sub, slice_ovf, less;
    logic [SLICE-1:0] a_s, b_s, b_eff, slice_res;
    logic [SLICE:0]   sum;
    logic [WIDTH-1:0] fin;

    assign accept = in_valid && (state_q == IDLE);
    assign last   = (cnt_q == CW'(N - 1));

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // One slice of the adder / logic unit, selected by the slice counter
    always_comb begin
        a_s    = a_q[int'(cnt_q) * SLICE +: SLICE];
        b_s    = b_q[int'(cnt_q) * SLICE +: SLICE];
        is_sub = (cmd_q == C_SUB) || (cmd_q == C_SLT);
        b_eff  = is_sub ? ~b_s : b_s;
        sum    = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
        case (cmd_q)
            C_XOR:   slice_res = a_s ^ b_s;
            C_AND:   slice_res = a_s & b_s;
            C_NAND:  slice_res = ~(a_s & b_s);
            C_NOR:   slice_res = ~(a_s | b_s);
            C_OR:    slice_res = a_s | b_s;
            default: slice_res = sum[SLICE-1:0];
        endcase
        // Equal operand signs with a differing sum sign == carry-in XOR carry-out at the MSB.
        slice_ovf = (a_s[SLICE-1] == b_eff[SLICE-1]) && (sum[SLICE-1] != a_s[SLICE-1]);
        less      = sum[SLICE-1] ^ slice_ovf;
    end

    always_comb begin
        cmd_d      = cmd_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        result_d   = result_q;
        carryout_d = carryout_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        fin        = acc_q;
        if (accept) begin
            cmd_d   = command;
            a_d     = operandA;
            b_d     = operandB;
            acc_d   = '0;
            cnt_d   = '0;
            carry_d = (command == C_SUB) || (command == C_SLT);
        end else if (state_q == RUN) begin
            fin[int'(cnt_q) * SLICE +: SLICE] = slice_res;
            acc_d   = fin;
            carry_d = sum[SLICE];
            cnt_d   = last ? '0 : cnt_q + CW'(1);
            if (last) begin
                carryout_d = 1'b0;
                overflow_d = 1'b0;
                if (cmd_q == C_ADD || cmd_q == C_SUB) begin
                    carryout_d = sum[SLICE];
                    overflow_d = slice_ovf;
                end else if (cmd_q == C_SLT) begin
                    fin    = '0;
                    fin[0] = less;
                end
                result_d = fin;
                zero_d   = ~|fin;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign carryout = carryout_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial: stimulus pushes expected results, monitor pops on output handshake.
module tb_alu_serial;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  command;
    logic [31:0] operandA, operandB, result;
    logic        carryout, zero, overflow;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    alu_serial #(.WIDTH(32), .SLICE(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .command(command), .operandA(operandA), .operandB(operandB),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carryout(carryout), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: out_ready is only changed just after posedge, so a negedge handshake is exactly one transfer.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got result %h with empty scoreboard", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("scoreboard {result,c,z,o}", 64'({result, carryout, zero, overflow}), 64'(e));
            end
        end
    end

    // Issue one request; returns #1 after the edge that raises out_valid.
    task automatic send(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec, input logic ez, input logic eo);
        int n;
        command = cmd; operandA = a; operandB = b; in_valid = 1'b1;
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        sb.push_back({er, ec, ez, eo});
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'd8);
    endtask

    task automatic run_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ec, input logic ez, input logic eo);
        send(cmd, a, b, er, ec, ez, eo);
        @(posedge clk); #1;
        chk("idle_after_handshake", 64'({in_ready, out_valid}), 64'b10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t snap;
        bit   seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        command = '0; operandA = '0; operandB = '0;
        #1;
        chk("reset_state", 64'({in_ready, out_valid, result, carryout, zero, overflow}),
            64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        run_op(3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1); // ADD ovf
        run_op(3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0); // ADD carry wrap
        run_op(3'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0); // SUB equal
        run_op(3'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0); // SUB borrow
        run_op(3'd5, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFFFF, 1'b0, 1'b0, 1'b0); // NAND
        run_op(3'd6, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0); // NOR
        run_op(3'd2, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b1, 1'b0); // XOR self
        run_op(3'd4, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 1'b0, 1'b0, 1'b0); // AND
        run_op(3'd7, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'hFCFCFCFC, 1'b0, 1'b0, 1'b0); // OR
        run_op(3'd3, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0); // SLT true
        run_op(3'd3, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0); // SLT false
        run_op(3'd3, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b0); // SLT ovf case

        // Backpressure: result must hold and new requests must be refused while out_ready is low.
        out_ready = 1'b0;
        send(3'd0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0);
        snap = {32'h23456789, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; command = 3'd1; operandA = 32'hDEAD0000 + i; operandB = 32'h1;
            @(posedge clk); #1;
            chk("stall_hold", 64'({result, carryout, zero, overflow}), 64'(snap));
            chk("stall_handshake", 64'({in_ready, out_valid}), 64'b01);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_ready", 64'({in_ready, out_valid}), 64'b10);
        chk("release_hold", 64'(result), 64'h23456789);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("no_stale_accept", 64'(seen), 64'd0);

        // Abort an ADD with reset during its third RUN cycle.
        command = 3'd0; operandA = 32'h00000010; operandB = 32'h00000020; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_immediate", 64'({in_ready, out_valid}), 64'b10);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        run_op(3'd0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_serial.md
# alu_serial

Parametrised, digit-serial ALU that generalises the single-bit logic slices (AND/NAND/NOR/OR/XOR) into a WIDTH-bit unit with the full lab command set. It processes SLICE bits per clock, which trades latency for area. It sits behind a valid/ready request port and drives a valid/ready result port, so a controller can issue one operation at a time and stall on the result.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be ≥ 2 and a multiple of SLICE.
- SLICE, 4, bits processed per RUN cycle; N = WIDTH/SLICE RUN cycles per operation.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- command  in  3  ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
- operandA  in  WIDTH  first operand, two's complement for arithmetic.
- operandB  in  WIDTH  second operand.
- out_valid  out  1  result and flags valid (DONE state).
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  operation result.
- carryout  out  1  carry out of MSB (ADD/SUB only).
- zero  out  1  result == 0.
- overflow  out  1  signed overflow (ADD/SUB only).

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. When in_valid && in_ready at an edge: latch command, operandA, operandB; clear slice counter, carry (1 for SUB/SLT, else 0), zero accumulator; go to RUN.
- RUN: each cycle, slice k (bits k·SLICE … k·SLICE+SLICE−1, k = 0 … N−1) is computed and written into the result register.
  - Logic ops: bitwise on the slice.
  - ADD: A + B + carry.
  - SUB/SLT: A + ~B + carry.
  - The slice carry-out is registered for slice k+1.
  - Inputs are ignored.
- After slice N−1: go to DONE. Final flags:
  - ADD/SUB: carryout = carry out of bit WIDTH−1; overflow = carry into MSB XOR carry out of MSB.
  - SLT: result = {WIDTH−1 zeros, less}, less = diff[MSB] XOR overflow_sub; carryout=0, overflow=0.
  - Logic ops: carryout=0, overflow=0.
  - zero is derived from the final result value, including the SLT result.
- DONE: out_valid=1. result and flags are held stable. in_ready=0; in_valid is ignored.
  - When out_ready is high at an edge: go to IDLE.
  - result and flags keep their values until the next completion. out_valid drops.
- Unsigned overflow and carry are reported only via flags; result wraps modulo 2^WIDTH.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, carryout=0, zero=0, overflow=0. The state counter is cleared.
- Latency: a request accepted at edge E sets out_valid high after edge E+N (N=8 for defaults).
- Throughput: at most one operation per N+2 cycles. in_ready rises the cycle after the output handshake; there is no same-cycle accept on the result handshake.
- out_valid and in_ready are never high together.
- Reset mid-RUN or mid-DONE aborts the operation: no out_valid is produced, and the unit is in IDLE (in_ready=1) as soon as reset asserts.
- out_ready held low indefinitely stalls the unit with no loss of the result.
- SLICE = WIDTH gives single-cycle RUN (N=1). The counter must handle N=1 without wrap error.

## Test plan
Defaults WIDTH=32, SLICE=4.
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow=1, carryout=0, zero=0; out_valid exactly 8 edges after accept.
- SUB 0x00000005 − 0x00000005 → result 0, zero=1, carryout=1, overflow=0. SUB 0 − 1 → 0xFFFFFFFF, carryout=0.
- NAND 0xFFFF0000, 0xFF00FF00 → 0x00FFFFFF. NOR 0, 0 → 0xFFFFFFFF. XOR A, A → 0 with zero=1; carryout=overflow=0.
- SLT 0x80000000 < 0x00000001 → result 1, zero=0. SLT 0x00000001, 0xFFFFFFFF → result 0, zero=1. SLT 0x7FFFFFFF vs 0x80000000 (overflow case) → result 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid with new operands. result and flags stay constant, in_ready stays 0, and the new request is not accepted. Raise out_ready; in_ready rises the next cycle.
- Assert reset for one cycle during the 3rd RUN cycle of an ADD. out_valid stays 0, in_ready=1 immediately, and no result appears. Then ADD 2 + 3 → 5 with correct 8-cycle latency.
